// File: rtl/bus_master_if.sv
// bus_master_if: per-core bus master front end placed in front of a round-robin
// bus arbiter. Accepts one load/store from the core, requests the bus, performs
// a single memory access on grant, waits out the fixed memory read latency, and
// returns read data plus a one-cycle done pulse. The request is dropped for one
// cycle after every transaction so the arbiter can rotate ownership.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   core_start/we/addr/wdata    transaction request from the core (sampled in IDLE)
//   core_busy, core_done        status back to the core
//   core_rdata                  last load result, held until the next load completes
//   bus_req, bus_gnt            request to / grant from the arbiter
//   bus_en/we/addr/wdata        memory access strobe and payload
//   bus_rdata                   memory read data
//   bus_err                     sticky: grant lost while waiting for read data

module bus_master_if #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MEM_LATENCY = 2   // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_start,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_busy,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    // Transaction sequencing, latch capture, latency count and error tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_start) begin
                        we_q    <= core_we;
                        addr_q  <= core_addr;
                        wdata_q <= core_wdata;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // The access itself is issued combinationally in the grant cycle.
                    if (bus_gnt) begin
                        if (we_q) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Losing the grant here is flagged but does not abort the load.
                    if (!bus_gnt) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        rdata_q <= bus_rdata;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status and bus outputs decode directly from the state register, so a
    // reset drops bus_req without waiting for a clock edge.
    assign core_busy  = (state_q != IDLE);
    assign core_done  = (state_q == DONE);
    assign core_rdata = rdata_q;
    assign bus_req    = (state_q == REQ) || (state_q == WAIT);
    assign bus_en     = (state_q == REQ) && bus_gnt;
    assign bus_we     = bus_en && we_q;
    assign bus_addr   = core_busy ? addr_q  : '0;
    assign bus_wdata  = core_busy ? wdata_q : '0;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: table-driven transactions, randomized
// transactions against a memory/latency reference model, and hand sequences for
// grant loss, mid-transaction reset, ignored overlapping start and two masters
// sharing a round-robin arbiter.

module tb_bus_master_if;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 64;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Master 0
    logic          s0, we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] wd0;
    logic          busy0, done0, req0, en0, bwe0, err0, gnt0;
    logic [AW-1:0] ba0;
    logic [DW-1:0] bwd0, rd0;
    // Master 1
    logic          s1, we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd1;
    logic          busy1, done1, req1, en1, bwe1, err1, gnt1;
    logic [AW-1:0] ba1;
    logic [DW-1:0] bwd1, rd1;

    logic [DW-1:0] mem_rdata;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) u0 (
        .clk(clk), .rst(rst),
        .core_start(s0), .core_we(we0), .core_addr(a0), .core_wdata(wd0),
        .core_busy(busy0), .core_done(done0), .core_rdata(rd0),
        .bus_req(req0), .bus_gnt(gnt0), .bus_en(en0), .bus_we(bwe0),
        .bus_addr(ba0), .bus_wdata(bwd0), .bus_rdata(mem_rdata), .bus_err(err0)
    );

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) u1 (
        .clk(clk), .rst(rst),
        .core_start(s1), .core_we(we1), .core_addr(a1), .core_wdata(wd1),
        .core_busy(busy1), .core_done(done1), .core_rdata(rd1),
        .bus_req(req1), .bus_gnt(gnt1), .bus_en(en1), .bus_we(bwe1),
        .bus_addr(ba1), .bus_wdata(bwd1), .bus_rdata(mem_rdata), .bus_err(err1)
    );

    // Grant source: either a simple blockable tie to req0, or a round-robin
    // arbiter that keeps the grant with its owner while the owner requests.
    logic arb_mode  = 1'b0;
    logic gnt_block = 1'b0;
    logic own_v_q, own_q, last_q;
    logic ag0, ag1;

    always_comb begin
        ag0 = 1'b0;
        ag1 = 1'b0;
        if (own_v_q && !own_q && req0)      ag0 = 1'b1;
        else if (own_v_q && own_q && req1)  ag1 = 1'b1;
        else if (req0 && req1) begin
            if (last_q) ag0 = 1'b1;
            else        ag1 = 1'b1;
        end
        else if (req0) ag0 = 1'b1;
        else if (req1) ag1 = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_v_q <= 1'b0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (ag0) begin
            own_v_q <= 1'b1;
            own_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (ag1) begin
            own_v_q <= 1'b1;
            own_q   <= 1'b1;
            last_q  <= 1'b1;
        end else begin
            own_v_q <= 1'b0;
        end
    end

    assign gnt0 = arb_mode ? ag0 : (req0 && !gnt_block);
    assign gnt1 = arb_mode ? ag1 : 1'b0;

    // Shared memory: synchronous write, read data valid LAT cycles after bus_en.
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [LAT];
    logic          mem_ready = 1'b0;

    assign m_en   = en0 | en1;
    assign m_we   = bwe0 | bwe1;
    assign m_addr = en1 ? ba1 : ba0;
    assign m_wd   = en1 ? bwd1 : bwd0;
    assign mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_ready <= 1'b1;
        end else begin
            if (m_en && m_we) mem[m_addr] <= m_wd;
            if (m_en) pipe[0] <= mem[m_addr];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Reference model: memory image and last load result.
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] ref_rd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction on master 0. The grant is held off for cycles 1..gdly and
    // also removed in cycle drop_at; with poke set, a conflicting core_start is
    // pulsed in cycle 2 and must be ignored.
    task automatic do_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int gdly, input int drop_at,
                          input bit poke, input int exp_done, input logic [DW-1:0] exp_rd);
        int            en_c, done_c;
        logic          en_we;
        logic [AW-1:0] en_addr;
        logic [DW-1:0] en_wd, done_rd;
        bit            idle_ok, stall_ok, req_ok;
        en_c = -1; done_c = -1; stall_ok = 1'b1; req_ok = 1'b1;
        en_we = 1'bx; en_addr = 'x; en_wd = 'x; done_rd = 'x;
        @(negedge clk);
        s0 = 1'b1; we0 = we; a0 = addr; wd0 = wd; gnt_block = 1'b0;
        #1;
        idle_ok = !busy0 && !req0 && !done0;
        for (int c = 1; c <= 100 && done_c < 0; c++) begin
            @(negedge clk);
            s0 = poke && (c == 2);
            if (s0) begin
                we0 = ~we; a0 = ~addr; wd0 = ~wd;
            end
            gnt_block = (c <= gdly) || (c == drop_at);
            #1;
            if (c <= gdly && (en0 || !busy0 || !req0)) stall_ok = 1'b0;
            if (en0 && en_c < 0) begin
                en_c = c; en_we = bwe0; en_addr = ba0; en_wd = bwd0;
            end
            if (!done0 && !req0) req_ok = 1'b0;
            if (done0 && req0)   req_ok = 1'b0;
            if (done0) begin
                done_c  = c;
                done_rd = rd0;
            end
        end
        gnt_block = 1'b0;
        chk({tag, " idle_before_start"}, 64'(idle_ok), 64'd1);
        chk({tag, " en_cycle"}, 64'(en_c), 64'(gdly + 1));
        chk({tag, " en_we"}, 64'(en_we), 64'(we));
        chk({tag, " en_addr"}, 64'(en_addr), 64'(addr));
        if (we) chk({tag, " en_wdata"}, en_wd, wd);
        chk({tag, " done_cycle"}, 64'(done_c), 64'(exp_done));
        chk({tag, " rdata"}, done_rd, exp_rd);
        chk({tag, " stall_hold"}, 64'(stall_ok), 64'd1);
        chk({tag, " req_shape"}, 64'(req_ok), 64'd1);
        if (we) ref_mem[addr] = wd;
        else    ref_rd = ref_mem[addr];
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            gdly;
        int            exp_done;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int            d0, d1, e0, e1, any_err, n_done;
        logic          rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rwd;
        int            rg;

        tbl[0] = '{1'b1, 8'h10, 64'hDEAD_BEEF,            0, 2, 64'h0};
        tbl[1] = '{1'b0, 8'h10, 64'h0,                    0, 4, 64'hDEAD_BEEF};
        tbl[2] = '{1'b1, 8'h20, 64'h1234,                 0, 2, 64'hDEAD_BEEF};
        tbl[3] = '{1'b0, 8'h20, 64'h0,                    0, 4, 64'h1234};
        tbl[4] = '{1'b0, 8'h30, 64'h0,                    5, 9, 64'h0};
        tbl[5] = '{1'b1, 8'h30, 64'hA5A5_0000_FFFF_1111,  5, 7, 64'h0};
        tbl[6] = '{1'b0, 8'h30, 64'h0,                    1, 5, 64'hA5A5_0000_FFFF_1111};
        tbl[7] = '{1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,  0, 2, 64'hA5A5_0000_FFFF_1111};
        tbl[8] = '{1'b0, 8'hFF, 64'h0,                    2, 6, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[9] = '{1'b0, 8'h00, 64'h0,                    0, 4, 64'h0};

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_rd = '0;
        s0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
        s1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy",  64'(busy0), 64'd0);
        chk("reset done",  64'(done0), 64'd0);
        chk("reset req",   64'(req0),  64'd0);
        chk("reset en",    64'({en0, bwe0}), 64'd0);
        chk("reset addr",  64'(ba0),   64'd0);
        chk("reset wdata", bwd0,       64'd0);
        chk("reset rdata", rd0,        64'd0);
        chk("reset err",   64'(err0),  64'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd,
                   tbl[i].gdly, -1, 1'b0, tbl[i].exp_done, tbl[i].exp_rd);
        end

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = AW'($urandom_range(0, 7) * 16);
            rwd = {$urandom, $urandom};
            rg  = int'($urandom_range(0, 3));
            do_txn($sformatf("rnd%0d", i), rw, ra, rwd, rg, -1, 1'b0,
                   rw ? rg + 2 : rg + int'(LAT) + 2, rw ? ref_rd : ref_mem[ra]);
        end
        chk("no_err_after_random", 64'(err0), 64'd0);

        // Ignored start while busy, for a load and a store
        do_txn("poke_load", 1'b0, 8'h10, 64'h0, 4, -1, 1'b1, 4 + int'(LAT) + 2, ref_mem[8'h10]);
        do_txn("poke_store", 1'b1, 8'h44, 64'h0123_4567_89AB_CDEF, 3, -1, 1'b1, 5, ref_rd);
        chk("no_err_after_poke", 64'(err0), 64'd0);

        // Grant loss in the first WAIT cycle: load still completes on schedule
        do_txn("gloss", 1'b0, 8'h44, 64'h0, 0, 2, 1'b0, int'(LAT) + 2, 64'h0123_4567_89AB_CDEF);
        chk("gloss err_set", 64'(err0), 64'd1);
        do_txn("gloss_next", 1'b1, 8'h50, 64'h55, 0, -1, 1'b0, 2, ref_rd);
        chk("gloss err_sticky", 64'(err0), 64'd1);

        // Reset during WAIT of a load
        @(negedge clk);
        s0 = 1'b1; we0 = 1'b0; a0 = 8'h20;
        @(negedge clk);
        s0 = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst in_wait_req", 64'(req0), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst req_drop", 64'(req0),  64'd0);
        chk("midrst busy",     64'(busy0), 64'd0);
        chk("midrst rdata",    rd0,        64'd0);
        chk("midrst err",      64'(err0),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_rd = '0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (done0) n_done++;
        end
        chk("midrst no_done", 64'(n_done), 64'd0);
        chk("midrst rdata_held", rd0, 64'd0);

        // Two masters behind the arbiter, simultaneous loads
        arb_mode = 1'b1;
        @(negedge clk);
        s0 = 1'b1; we0 = 1'b0; a0 = 8'h10;
        s1 = 1'b1; we1 = 1'b0; a1 = 8'h30;
        d0 = -1; d1 = -1; e0 = -1; e1 = -1; any_err = 0;
        for (int c = 1; c <= 60 && (d0 < 0 || d1 < 0); c++) begin
            @(negedge clk);
            s0 = 1'b0; s1 = 1'b0;
            #1;
            if (en0 && e0 < 0) e0 = c;
            if (en1 && e1 < 0) e1 = c;
            if (done0 && d0 < 0) d0 = c;
            if (done1 && d1 < 0) d1 = c;
            if (err0 || err1) any_err = 1;
        end
        chk("arb core0_en",   64'(e0), 64'd1);
        chk("arb core0_done", 64'(d0), 64'(int'(LAT) + 2));
        chk("arb core1_after_drop", 64'((e1 == d0) || (e1 == d0 + 1)), 64'd1);
        chk("arb core1_done", 64'(d1), 64'(e1 + int'(LAT) + 1));
        chk("arb rdata0", rd0, ref_mem[8'h10]);
        chk("arb rdata1", rd1, ref_mem[8'h30]);
        chk("arb no_err", 64'(any_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
